cpu_control_unit: RTL and testbench

- Multi-cycle control FSM for the 16-bit datapath.
- Fetches instructions from instruction memory, holds the instruction register (IR), and sequences the 16x16 register file, the data memory and the ALU.
- Generates every register-file read/write address, write enable, write-data mux select and ALU opcode.
- One instruction completes per 3 cycles (NOOP/STORE/ADD/SUB) or 4 cycles (LOAD).

---
 rtl/cpu_control_unit_if.sv | 36 +++
 rtl/cpu_control_unit.sv | 149 ++++++++++++++
 tb/tb_cpu_control_unit.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_control_unit_if.sv
// Control-unit bus: instruction fetch, data memory strobes, register-file/ALU controls and status.
interface cpu_control_unit_if #(
  parameter int PC_WIDTH    = 7,
  parameter int DADDR_WIDTH = 8
);
  logic                   run;
  logic [15:0]            instr_data;
  logic [PC_WIDTH-1:0]    pc_addr;
  logic [15:0]            ir_out;
  logic [DADDR_WIDTH-1:0] d_addr;
  logic                   d_rd;
  logic                   d_wr;
  logic [3:0]             rf_ra_addr;
  logic [3:0]             rf_rb_addr;
  logic [3:0]             rf_w_addr;
  logic                   rf_w_wr;
  logic                   rf_sel;
  logic [2:0]             alu_op;
  logic                   halted;
  logic                   illegal_op;
  logic [3:0]             state_dbg;

  modport master (
    input  run, instr_data,
    output pc_addr, ir_out, d_addr, d_rd, d_wr,
           rf_ra_addr, rf_rb_addr, rf_w_addr, rf_w_wr, rf_sel,
           alu_op, halted, illegal_op, state_dbg
  );

  modport slave (
    output run, instr_data,
    input  pc_addr, ir_out, d_addr, d_rd, d_wr,
           rf_ra_addr, rf_rb_addr, rf_w_addr, rf_w_wr, rf_sel,
           alu_op, halted, illegal_op, state_dbg
  );
endinterface

// File: rtl/cpu_control_unit.sv
// Multi-cycle control FSM for the 16-bit datapath: fetch, decode and sequence RF/ALU/data memory.
// state   | meaning
// INIT    | one settle cycle with pc_addr = 0
// FETCH   | latch IR and bump PC when run is high
// DECODE  | select execute state from IR[15:12], flag illegal opcodes
// NOOP    | idle cycle, also taken after an illegal opcode
// LOAD_A  | data memory read of IR[7:0]
// LOAD_B  | write memory data into RF[IR[11:8]]
// STORE   | write RF[IR[11:8]] to data memory at IR[7:0]
// ADD/SUB | RF[IR[3:0]] <= RF[IR[11:8]] +/- RF[IR[7:4]]
// HALT    | parked until reset
module cpu_control_unit #(
  parameter int PC_WIDTH    = 7,
  parameter int DADDR_WIDTH = 8
) (
  input logic                clk,
  input logic                rst_n,
  cpu_control_unit_if.master bus
);

  typedef enum logic [3:0] {
    INIT   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    NOOP   = 4'd3,
    LOAD_A = 4'd4,
    LOAD_B = 4'd5,
    STORE  = 4'd6,
    ADD    = 4'd7,
    SUB    = 4'd8,
    HALT   = 4'd9
  } stateT;

  stateT                  state, nextState;
  logic [PC_WIDTH-1:0]    pc, pcNext;
  logic [15:0]            ir, irNext;
  logic                   illegalOp, illegalNext;
  logic [3:0]             opcode;

  logic [DADDR_WIDTH-1:0] dAddr;
  logic                   dRd, dWr;
  logic [3:0]             raAddr, rbAddr, wAddr;
  logic                   wWr, rfSel;
  logic [2:0]             aluOp;
  logic                   haltedNow;

  assign opcode = ir[15:12];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      pc        <= '0;
      ir        <= '0;
      illegalOp <= 1'b0;
    end else begin
      state     <= nextState;
      pc        <= pcNext;
      ir        <= irNext;
      illegalOp <= illegalNext;
    end
  end

  always_comb begin
    nextState   = state;
    pcNext      = pc;
    irNext      = ir;
    illegalNext = illegalOp;
    dAddr       = '0;
    dRd         = 1'b0;
    dWr         = 1'b0;
    raAddr      = '0;
    rbAddr      = '0;
    wAddr       = '0;
    wWr         = 1'b0;
    rfSel       = 1'b0;
    aluOp       = 3'b000;
    haltedNow   = 1'b0;

    unique case (state)
      INIT: nextState = FETCH;
      FETCH: begin
        if (bus.run) begin
          irNext    = bus.instr_data;
          pcNext    = pc + PC_WIDTH'(1);
          nextState = DECODE;
        end
      end
      DECODE: begin
        unique case (opcode)
          4'h0:    nextState = NOOP;
          4'h1:    nextState = STORE;
          4'h2:    nextState = LOAD_A;
          4'h3:    nextState = ADD;
          4'h4:    nextState = SUB;
          4'h5:    nextState = HALT;
          default: begin
            illegalNext = 1'b1;
            nextState   = NOOP;
          end
        endcase
      end
      NOOP: nextState = FETCH;
      LOAD_A: begin
        dAddr     = ir[DADDR_WIDTH-1:0];
        dRd       = 1'b1;
        nextState = LOAD_B;
      end
      LOAD_B: begin
        dAddr     = ir[DADDR_WIDTH-1:0];
        rfSel     = 1'b1;
        wAddr     = ir[11:8];
        wWr       = 1'b1;
        nextState = FETCH;
      end
      STORE: begin
        raAddr    = ir[11:8];
        dAddr     = ir[DADDR_WIDTH-1:0];
        dWr       = 1'b1;
        nextState = FETCH;
      end
      ADD, SUB: begin
        raAddr    = ir[11:8];
        rbAddr    = ir[7:4];
        wAddr     = ir[3:0];
        wWr       = 1'b1;
        aluOp     = (state == ADD) ? 3'b001 : 3'b010;
        nextState = FETCH;
      end
      HALT: haltedNow = 1'b1;
      default: nextState = INIT;
    endcase
  end

  assign bus.pc_addr    = pc;
  assign bus.ir_out     = ir;
  assign bus.d_addr     = dAddr;
  assign bus.d_rd       = dRd;
  assign bus.d_wr       = dWr;
  assign bus.rf_ra_addr = raAddr;
  assign bus.rf_rb_addr = rbAddr;
  assign bus.rf_w_addr  = wAddr;
  assign bus.rf_w_wr    = wWr;
  assign bus.rf_sel     = rfSel;
  assign bus.alu_op     = aluOp;
  assign bus.halted     = haltedNow;
  assign bus.illegal_op = illegalOp;
  assign bus.state_dbg  = state;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Scoreboard bench for cpu_control_unit: per-cycle expected outputs queued at issue, checked by a monitor.
module tb_cpu_control_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cpu_control_unit_if #(.PC_WIDTH(7), .DADDR_WIDTH(8)) bus();
  cpu_control_unit #(.PC_WIDTH(7), .DADDR_WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic [3:0]  st;
    logic [6:0]  pc;
    logic [15:0] ir;
    logic [7:0]  dAddr;
    logic        dRd;
    logic        dWr;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [3:0]  wa;
    logic        wWr;
    logic        sel;
    logic [2:0]  alu;
    logic        halted;
    logic        ill;
  } obsT;

  obsT         expQ[$];
  int          passCnt = 0;
  int          totalCnt = 0;
  bit          track = 1'b0;
  bit          wroteInReset = 1'b0;
  logic [15:0] imem[128];
  logic [6:0]  mPc;
  logic [15:0] mIr;
  logic        mIll;

  always @(posedge clk) bus.instr_data <= imem[bus.pc_addr];
  always @(posedge clk) if (!rst_n && bus.rf_w_wr) wroteInReset = 1'b1;

  function automatic obsT sample();
    obsT o;
    o.st = bus.state_dbg;     o.pc = bus.pc_addr;      o.ir = bus.ir_out;
    o.dAddr = bus.d_addr;     o.dRd = bus.d_rd;        o.dWr = bus.d_wr;
    o.ra = bus.rf_ra_addr;    o.rb = bus.rf_rb_addr;   o.wa = bus.rf_w_addr;
    o.wWr = bus.rf_w_wr;      o.sel = bus.rf_sel;      o.alu = bus.alu_op;
    o.halted = bus.halted;    o.ill = bus.illegal_op;
    return o;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (track) begin
      if (expQ.size() == 0) begin
        totalCnt++;
        $display("FAIL sb_underflow: got output with no expected entry, state %0d", bus.state_dbg);
      end else begin
        obsT e;
        e = expQ.pop_front();
        chk("sb_cycle", 64'(sample()), 64'(e));
      end
    end
  end

  function automatic obsT base(input logic [3:0] st);
    obsT o;
    o = '0;
    o.st = st; o.pc = mPc; o.ir = mIr; o.ill = mIll;
    return o;
  endfunction

  task automatic issue(input logic [15:0] ins);
    obsT o;
    expQ.push_back(base(4'd1));
    mIr = ins;
    mPc = mPc + 7'd1;
    expQ.push_back(base(4'd2));
    case (ins[15:12])
      4'h0: expQ.push_back(base(4'd3));
      4'h1: begin
        o = base(4'd6); o.ra = ins[11:8]; o.dAddr = ins[7:0]; o.dWr = 1'b1;
        expQ.push_back(o);
      end
      4'h2: begin
        o = base(4'd4); o.dAddr = ins[7:0]; o.dRd = 1'b1;
        expQ.push_back(o);
        o = base(4'd5); o.dAddr = ins[7:0]; o.sel = 1'b1; o.wa = ins[11:8]; o.wWr = 1'b1;
        expQ.push_back(o);
      end
      4'h3, 4'h4: begin
        o = base((ins[15:12] == 4'h3) ? 4'd7 : 4'd8);
        o.ra = ins[11:8]; o.rb = ins[7:4]; o.wa = ins[3:0]; o.wWr = 1'b1;
        o.alu = (ins[15:12] == 4'h3) ? 3'b001 : 3'b010;
        expQ.push_back(o);
      end
      4'h5: begin
        for (int i = 0; i < 20; i++) begin
          o = base(4'd9); o.halted = 1'b1;
          expQ.push_back(o);
        end
      end
      default: begin
        mIll = 1'b1;
        expQ.push_back(base(4'd3));
      end
    endcase
  endtask

  task automatic waitFetch();
    int n;
    n = 0;
    while (bus.state_dbg != 4'd1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (bus.state_dbg != 4'd1) begin
      totalCnt++;
      $display("FAIL wait_fetch: timed out, state %0d", bus.state_dbg);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expQ.size() > 0 && n < 2000) begin
      @(posedge clk); #1;
      if (bus.state_dbg == 4'd9) bus.run = ~bus.run;
      n++;
    end
    if (expQ.size() > 0) begin
      totalCnt++;
      $display("FAIL drain_timeout: %0d entries left", expQ.size());
    end
    expQ.delete();
    track = 1'b0;
    bus.run = 1'b0;
  endtask

  task automatic applyReset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_state", 64'(bus.state_dbg), 64'd0);
    chk("rst_pc_ill", 64'({bus.pc_addr, bus.illegal_op}), 64'd0);
    chk("rst_strobes", 64'({bus.d_rd, bus.d_wr, bus.rf_w_wr, bus.d_addr, bus.rf_w_addr}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.run = 1'b0;
    for (int i = 0; i < 128; i++) imem[i] = 16'h0000;
    imem[0] = 16'h2305; imem[1] = 16'h3123; imem[2] = 16'h4A5B; imem[3] = 16'h1480;
    imem[4] = 16'h0000; imem[5] = 16'hF000; imem[6] = 16'h0000; imem[7] = 16'h3123;
    imem[8] = 16'h1480; imem[9] = 16'h5000;

    #2;
    chk("rst_state", 64'(bus.state_dbg), 64'd0);
    chk("rst_pc_ir", 64'({bus.pc_addr, bus.ir_out, bus.illegal_op}), 64'd0);
    chk("rst_strobes", 64'({bus.d_rd, bus.d_wr, bus.rf_w_wr, bus.d_addr,
                            bus.rf_ra_addr, bus.rf_rb_addr, bus.rf_w_addr}), 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Stall in FETCH with run low, then run the main program through HALT.
    waitFetch();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall_state", 64'(bus.state_dbg), 64'd1);
      chk("stall_pc_ir", 64'({bus.pc_addr, bus.ir_out}), 64'd0);
    end
    @(posedge clk); #1;
    bus.run = 1'b1;
    mPc = 7'd0; mIr = 16'h0000; mIll = 1'b0;
    for (int i = 0; i < 10; i++) issue(imem[i]);
    track = 1'b1;
    drain();

    // Reset mid LOAD_B: write strobe must drop at once and never reach a clock edge.
    applyReset();
    bus.run = 1'b1;
    begin
      int n;
      n = 0;
      while (bus.state_dbg != 4'd5 && n < 30) begin
        @(posedge clk); #2;
        n++;
      end
    end
    chk("loadb_reached", 64'({bus.state_dbg, bus.rf_w_wr, bus.rf_w_addr}), 64'({4'd5, 1'b1, 4'd3}));
    wroteInReset = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_rst_wr", 64'({bus.rf_w_wr, bus.rf_sel, bus.d_addr}), 64'd0);
    chk("async_rst_st_pc", 64'({bus.state_dbg, bus.pc_addr}), 64'd0);
    @(posedge clk); #1;
    chk("no_write_in_rst", 64'({wroteInReset, bus.rf_w_wr}), 64'd0);
    bus.run = 1'b0;
    for (int i = 0; i < 128; i++) imem[i] = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;

    // NOOP stream across the PC wrap.
    waitFetch();
    @(posedge clk); #1;
    bus.run = 1'b1;
    mPc = 7'd0; mIr = 16'h0000; mIll = 1'b0;
    for (int i = 0; i < 129; i++) issue(16'h0000);
    track = 1'b1;
    drain();

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
